spi_rom_reader: RTL and testbench
=================================

Name: spi_rom_reader

Overview:
- SPI mode-3 master (CPOL=1, CPHA=1) that sits directly upstream of the SPI BRAM ROM slave.
- Drives ss/sclk/mosi and samples miso, reading `len` bytes sequentially from ROM address 0. The slave resets its pointer on ss high.
- Presents each received byte on a single-entry valid/ready output port.
- Stalls sclk high (idle level) when the consumer applies back-pressure; this is legal because the slave holds its state while sclk is static.

Parameters:
CLKDIV, 2, sclk half-period in clk cycles; legal range >= 1.
LENW, 8, width of the byte-count input.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a read transaction.
len  input  LENW  number of bytes to read; sampled when start is accepted.
busy  output  1  high from start acceptance until done.
done  output  1  one-cycle pulse at end of transaction.
dout  output  8  received byte, MSB-first assembled.
dout_valid  output  1  dout holds an unconsumed byte.
dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready.
ss  output  1  active-low slave select.
sclk  output  1  SPI clock; idles high.
mosi  output  1  constant 0; the ROM ignores it.
miso  input  1  slave data; the slave changes it on sclk falling edge.

Behaviour:
- Reset values: ss=1, sclk=1, mosi=0, busy=0, done=0, dout_valid=0, dout=0. State = IDLE. Internal counters are cleared.
- Reset mid-transaction: all of the above take effect at the next edge. ss rises immediately, no done pulse, and any pending byte is discarded.
- All outputs are registered. ss and sclk come straight from flops, with no combinational path from inputs.
- FSM states: IDLE, SETUP, LOW, HIGH, HOLD, END.
- IDLE:
  - On start && len!=0: latch len into remaining, set busy=1, ss=0, go to SETUP.
  - start with len==0 is ignored (busy stays 0, no done).
  - start while busy is ignored.
- SETUP: hold ss=0, sclk=1 for CLKDIV cycles, then drive sclk=0 and go to LOW.
- LOW: sclk=0 for CLKDIV cycles. At the final edge, drive sclk=1, shift miso into the LSB of the shift register (MSB-first), increment bit count, and go to HIGH.
- HIGH: sclk=1 for CLKDIV cycles. At the end of the phase:
  - If bit count < 8: drive sclk=0 and go to LOW.
  - If bit count == 8: the byte is complete. Try to load it into dout.
    - Load is permitted when dout_valid==0, or when dout_ready==1 in the same cycle (simultaneous consume and load; dout_valid stays 1).
    - If the load succeeds: decrement remaining and clear bit count. If remaining is still nonzero, drive sclk=0 and go to LOW; otherwise go to END.
    - If the load is blocked: go to HOLD.
- HOLD: sclk stays 1 and ss stays 0. Retry the load every cycle. When it succeeds, resume as in the HIGH completion step: the next falling edge, if any, comes on the same edge as the load.
- END: drive ss=1 and keep it high for CLKDIV cycles (minimum deselect time). Then pulse done=1 for one cycle, set busy=0, and return to IDLE.
  - done is independent of whether the last byte has been consumed; dout_valid may remain 1 after done.
  - A new start may be accepted on the cycle after done.
- Output handshake:
  - dout_valid clears on a consume with no simultaneous load.
  - dout is stable while dout_valid=1 && dout_ready=0.
- Timing, unstalled, per byte: 16*CLKDIV clk cycles. sclk has exactly 8 falling and 8 rising edges per byte, and exactly 8*len of each per transaction.
- Sample point: miso is sampled at the clk edge that raises sclk, i.e. CLKDIV cycles after the slave updated miso on the falling edge.
- Byte order: byte k is ROM address k. A single transaction never wraps; the slave wraps internally if len exceeds ROM size, and the reader simply continues.
- Bit counter is 4 bits. remaining is LENW bits.

Test Plan:
- Reset, then idle 20 cycles -> ss=1, sclk=1, busy=0, done=0, dout_valid=0 throughout.
- ROM preloaded 8'hA5,8'h3C, CLKDIV=2; start with len=2 and dout_ready=1:
  - dout_valid pulses with 8'hA5 then 8'h3C, bytes 32 clks apart.
  - 16 sclk falls counted.
  - ss high CLKDIV cycles before the done pulse.
- len=3 with dout_ready=0 until 100 cycles after the first valid:
  - sclk held high and ss low during the stall.
  - No extra sclk edges.
  - dout stable at byte 0.
  - After ready, bytes 1 and 2 are correct.
- len=0 start -> no ss assertion, busy stays 0, no done. Then start while busy during a len=2 read -> ignored, exactly 2 bytes delivered.
- Reset asserted mid-byte (after 3 sclk falls) -> ss=1, sclk=1, dout_valid=0 next edge. A following len=1 read returns ROM[0] correctly.
- CLKDIV=1, len=9 on an 8-entry ROM, ready tied high -> 9 bytes ROM[0..7],ROM[0], back-to-back at 16-cycle spacing.

Source files
------------

// File: rtl/spi_rom_reader.sv
// SPI mode-3 master that streams `len` bytes from an SPI ROM slave starting at address 0
// and hands each byte to a single-entry valid/ready output register.
module spi_rom_reader #(
    parameter int CLKDIV = 2,
    parameter int LENW   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [LENW-1:0] len,
    output logic            busy,
    output logic            done,
    output logic [7:0]      dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            ss,
    output logic            sclk,
    output logic            mosi,
    input  logic            miso
);
    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKDIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_LOW, ST_HIGH, ST_HOLD, ST_END
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      bitcnt_q;
    logic [LENW-1:0] rem_q;
    logic [LENW-1:0] rem_d;
    logic [7:0]      shift_q;
    logic [7:0]      dout_q;
    logic            busy_q;
    logic            done_q;
    logic            valid_q;
    logic            ss_q;
    logic            sclk_q;

    logic phase_end;
    logic byte_full;
    logic load_go;

    // A completed byte is loaded at the end of its HIGH phase or on any HOLD cycle,
    // as long as the output slot is free or being consumed in the same cycle.
    always_comb begin
        phase_end = (cnt_q == CNT_LAST);
        byte_full = (bitcnt_q == 4'd8);
        rem_d     = rem_q - LENW'(1);
        load_go   = ((state_q == ST_HIGH && phase_end && byte_full) || state_q == ST_HOLD)
                    && (!valid_q || dout_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            rem_q    <= '0;
            shift_q  <= '0;
            dout_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            ss_q     <= 1'b1;
            sclk_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            if (valid_q && dout_ready) begin
                valid_q <= 1'b0;
            end
            if (load_go) begin
                dout_q   <= shift_q;
                valid_q  <= 1'b1;
                rem_q    <= rem_d;
                bitcnt_q <= '0;
                cnt_q    <= '0;
                if (rem_d != '0) begin
                    sclk_q  <= 1'b0;
                    state_q <= ST_LOW;
                end else begin
                    ss_q    <= 1'b1;
                    state_q <= ST_END;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start && len != '0) begin
                            rem_q    <= len;
                            busy_q   <= 1'b1;
                            ss_q     <= 1'b0;
                            cnt_q    <= '0;
                            bitcnt_q <= '0;
                            state_q  <= ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        if (phase_end) begin
                            cnt_q   <= '0;
                            sclk_q  <= 1'b0;
                            state_q <= ST_LOW;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_LOW: begin
                        // Rising sclk edge: miso has been stable for a full half-period.
                        if (phase_end) begin
                            cnt_q    <= '0;
                            sclk_q   <= 1'b1;
                            shift_q  <= {shift_q[6:0], miso};
                            bitcnt_q <= bitcnt_q + 4'd1;
                            state_q  <= ST_HIGH;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_HIGH: begin
                        if (phase_end) begin
                            cnt_q <= '0;
                            if (!byte_full) begin
                                sclk_q  <= 1'b0;
                                state_q <= ST_LOW;
                            end else begin
                                state_q <= ST_HOLD;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_HOLD: begin
                        state_q <= ST_HOLD;
                    end
                    ST_END: begin
                        if (phase_end) begin
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign ss         = ss_q;
    assign sclk       = sclk_q;
    assign mosi       = 1'b0;

endmodule

// File: tb/tb_spi_rom_reader.sv
// Bench for spi_rom_reader: two instances (CLKDIV=2 and CLKDIV=1), each wired to a
// behavioural mode-3 ROM slave, with a queue scoreboard fed at start and drained by monitors.
module tb_spi_rom_reader;
    localparam int LENW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic            reset0, start0, busy0, done0, dout_valid0, dout_ready0, ss0, sclk0, mosi0, miso0;
    logic [LENW-1:0] len0;
    logic [7:0]      dout0;
    logic            reset1, start1, busy1, done1, dout_valid1, dout_ready1, ss1, sclk1, mosi1, miso1;
    logic [LENW-1:0] len1;
    logic [7:0]      dout1;

    spi_rom_reader #(.CLKDIV(2), .LENW(LENW)) u_dut0 (
        .clk(clk), .reset(reset0), .start(start0), .len(len0), .busy(busy0), .done(done0),
        .dout(dout0), .dout_valid(dout_valid0), .dout_ready(dout_ready0),
        .ss(ss0), .sclk(sclk0), .mosi(mosi0), .miso(miso0)
    );

    spi_rom_reader #(.CLKDIV(1), .LENW(LENW)) u_dut1 (
        .clk(clk), .reset(reset1), .start(start1), .len(len1), .busy(busy1), .done(done1),
        .dout(dout1), .dout_valid(dout_valid1), .dout_ready(dout_ready1),
        .ss(ss1), .sclk(sclk1), .mosi(mosi1), .miso(miso1)
    );

    logic [7:0] rom [8];

    // ROM slave: pointer resets on ss high; the n-th falling edge of a selection
    // presents bit 7-(n%8) of byte n/8 (wrapping every 8 bytes).
    int sl_falls0 = 0, sl_falls1 = 0;
    int tot_falls0 = 0, tot_rises0 = 0, tot_falls1 = 0, tot_rises1 = 0;
    logic [7:0] sl_byte0, sl_byte1;

    always @(posedge ss0) sl_falls0 = 0;
    always @(posedge ss1) sl_falls1 = 0;
    always @(posedge sclk0) tot_rises0++;
    always @(posedge sclk1) tot_rises1++;
    always @(negedge sclk0) begin
        tot_falls0++;
        if (ss0 === 1'b0) begin
            sl_byte0 = rom[(sl_falls0 / 8) % 8];
            miso0 = sl_byte0[7 - (sl_falls0 % 8)];
            sl_falls0++;
        end
    end
    always @(negedge sclk1) begin
        tot_falls1++;
        if (ss1 === 1'b0) begin
            sl_byte1 = rom[(sl_falls1 / 8) % 8];
            miso1 = sl_byte1[7 - (sl_falls1 % 8)];
            sl_falls1++;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    // Monitors: pop one expected byte per accepted handshake.
    int   last_acc0 = -1, last_acc1 = -1;
    bit   chk_space0 = 1'b0;
    int   ss_run0 = 0, ss_run1 = 0;
    int   done_cnt0 = 0;
    bit   stall_prev0 = 1'b0;
    logic [7:0] dout_prev0 = '0;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (dout_valid0 === 1'b1 && stall_prev0) check("dout_stable0", dout0, dout_prev0);
        stall_prev0 = (dout_valid0 === 1'b1) && (dout_ready0 === 1'b0);
        dout_prev0  = dout0;
        if (dout_valid0 === 1'b1 && dout_ready0 === 1'b1) begin
            check("byte0_expected", 32'(exp_q0.size() != 0), 1);
            if (exp_q0.size() != 0) begin
                exp_b = exp_q0.pop_front();
                check("byte0", dout0, exp_b);
            end
            if (chk_space0 && last_acc0 >= 0) check("spacing0", cyc - last_acc0, 32);
            last_acc0 = cyc;
        end
        if (done0 === 1'b1) begin
            done_cnt0++;
            check("ss_before_done0", ss_run0, 2);
        end
        ss_run0 = (ss0 === 1'b1) ? ss_run0 + 1 : 0;
    end

    always @(negedge clk) begin
        if (dout_valid1 === 1'b1 && dout_ready1 === 1'b1) begin
            check("byte1_expected", 32'(exp_q1.size() != 0), 1);
            if (exp_q1.size() != 0) check("byte1", dout1, exp_q1.pop_front());
            if (last_acc1 >= 0) check("spacing1", cyc - last_acc1, 16);
            last_acc1 = cyc;
        end
        if (done1 === 1'b1) check("ss_before_done1", ss_run1, 1);
        ss_run1 = (ss1 === 1'b1) ? ss_run1 + 1 : 0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int which, input int n);
        step();
        if (which == 0) begin
            tot_falls0 = 0; tot_rises0 = 0; last_acc0 = -1;
            for (int k = 0; k < n; k++) exp_q0.push_back(rom[k % 8]);
            start0 = 1'b1; len0 = LENW'(n);
        end else begin
            tot_falls1 = 0; tot_rises1 = 0; last_acc1 = -1;
            for (int k = 0; k < n; k++) exp_q1.push_back(rom[k % 8]);
            start1 = 1'b1; len1 = LENW'(n);
        end
        step();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    bit rand_ready0 = 1'b0;

    task automatic wait_done(input int which, input int budget, input string name);
        int t;
        for (t = 0; t < budget; t++) begin
            step();
            if (which == 0 && rand_ready0) dout_ready0 = 1'($urandom_range(0, 1));
            if (((which == 0) ? done0 : done1) === 1'b1) break;
        end
        check({name, "_done_in_time"}, 32'(t < budget), 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int t;
        int n;

        rom[0] = 8'hA5;
        rom[1] = 8'h3C;
        for (int i = 2; i < 8; i++) rom[i] = 8'($urandom_range(0, 255));

        reset0 = 1'b1; start0 = 1'b0; len0 = '0; dout_ready0 = 1'b1; miso0 = 1'b0;
        reset1 = 1'b1; start1 = 1'b0; len1 = '0; dout_ready1 = 1'b1; miso1 = 1'b0;
        repeat (3) step();
        reset0 = 1'b0;
        reset1 = 1'b0;

        // Reset values and a quiet idle period.
        check("rst_ss0", ss0, 1);
        check("rst_sclk0", sclk0, 1);
        check("rst_mosi0", mosi0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_done0", done0, 0);
        check("rst_valid0", dout_valid0, 0);
        check("rst_dout0", dout0, 0);
        check("rst_ss1", ss1, 1);
        check("rst_sclk1", sclk1, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ss0 !== 1'b1 || sclk0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || dout_valid0 !== 1'b0) bad++;
        end
        check("idle_20_cycles", bad, 0);

        // Two bytes, consumer always ready: 32-cycle spacing, 16 sclk edges each way.
        dout_ready0 = 1'b1;
        chk_space0  = 1'b1;
        issue(0, 2);
        check("busy_after_start", busy0, 1);
        check("ss_low_after_start", ss0, 0);
        wait_done(0, 400, "two_bytes");
        chk_space0 = 1'b0;
        repeat (3) step();
        check("two_bytes_drained", exp_q0.size(), 0);
        check("two_bytes_falls", tot_falls0, 16);
        check("two_bytes_rises", tot_rises0, 16);
        check("two_bytes_idle_busy", busy0, 0);

        // Back-pressure: consumer stalls for 100 cycles after the first byte.
        dout_ready0 = 1'b0;
        issue(0, 3);
        for (t = 0; t < 300; t++) begin
            step();
            if (dout_valid0 === 1'b1) break;
        end
        check("stall_first_valid_in_time", 32'(t < 300), 1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (i >= 40 && (ss0 !== 1'b0 || sclk0 !== 1'b1 || dout0 !== rom[0] || dout_valid0 !== 1'b1)) bad++;
        end
        check("stall_hold", bad, 0);
        check("stall_falls", tot_falls0, 16);
        check("stall_rises", tot_rises0, 16);
        dout_ready0 = 1'b1;
        wait_done(0, 400, "stall");
        repeat (3) step();
        check("stall_drained", exp_q0.size(), 0);
        check("stall_falls_total", tot_falls0, 24);
        check("stall_rises_total", tot_rises0, 24);

        // len == 0 is ignored.
        done_cnt0 = 0;
        issue(0, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ss0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) bad++;
        end
        check("len0_ignored", bad, 0);
        check("len0_no_done", done_cnt0, 0);

        // A start while busy is ignored.
        issue(0, 2);
        repeat (10) step();
        check("busy_mid_read", busy0, 1);
        start0 = 1'b1;
        len0   = LENW'(5);
        step();
        start0 = 1'b0;
        wait_done(0, 400, "busy_start");
        repeat (60) step();
        check("busy_start_drained", exp_q0.size(), 0);
        check("busy_start_falls", tot_falls0, 16);
        check("busy_start_one_done", done_cnt0, 1);
        check("busy_start_idle", busy0, 0);

        // Reset after the third falling edge of byte 0.
        issue(0, 2);
        for (t = 0; t < 200; t++) begin
            if (tot_falls0 >= 3) break;
            step();
        end
        check("midreset_reach_3_falls", tot_falls0, 3);
        reset0 = 1'b1;
        step();
        check("midreset_ss", ss0, 1);
        check("midreset_sclk", sclk0, 1);
        check("midreset_valid", dout_valid0, 0);
        check("midreset_busy", busy0, 0);
        check("midreset_done", done0, 0);
        reset0 = 1'b0;
        exp_q0.delete();
        issue(0, 1);
        wait_done(0, 300, "after_reset");
        repeat (3) step();
        check("after_reset_drained", exp_q0.size(), 0);
        check("after_reset_falls", tot_falls0, 8);

        // Random lengths with a randomly stalling consumer.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 10);
            rand_ready0 = 1'b1;
            issue(0, n);
            wait_done(0, 3000, "random");
            rand_ready0 = 1'b0;
            dout_ready0 = 1'b1;
            repeat (3) step();
            check("random_drained", exp_q0.size(), 0);
            check("random_falls", tot_falls0, 8 * n);
            check("random_rises", tot_rises0, 8 * n);
        end

        // CLKDIV=1, nine bytes from an eight-entry ROM: the slave wraps, reader continues.
        dout_ready1 = 1'b1;
        issue(1, 9);
        wait_done(1, 400, "wrap");
        repeat (3) step();
        check("wrap_drained", exp_q1.size(), 0);
        check("wrap_falls", tot_falls1, 72);
        check("wrap_rises", tot_rises1, 72);
        check("wrap_idle_busy", busy1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
